mlp_mul_pipe: RTL and testbench

- Parametrised, pipelined multiply / multiply-accumulate unit for the mlp datapath.
- Successor to the combinational fixed-signedness multiplier cores.
- Adds per-operand signedness, configurable pipeline depth with clock-enable and valid tracking, and an optional running accumulate mode.
- Used by dense-layer engines that need timing-closed MACs at one beat per clock.

---
 rtl/mlp_mul_pipe_if.sv | 27 ++
 rtl/mlp_mul_pipe.sv | 146 ++++++++++++++
 tb/tb_mlp_mul_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mlp_mul_pipe_if.sv
// Operand, control and result bundle for mlp_mul_pipe.
// The master drives the beats and the slave returns the results.
interface mlp_mul_pipe_if #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 31
);
    logic                  ce;
    logic                  in_valid;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output ce, in_valid, din0, din1, acc_en, acc_clr,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  ce, in_valid, din0, din1, acc_en, acc_clr,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/mlp_mul_pipe.sv
// Pipelined multiply / multiply-accumulate with per-operand signedness and clock-enable.
// Define MLP_MUL_PIPE_SAT_EN to saturate results and accumulator instead of wrapping.
module mlp_mul_pipe #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 15,
    parameter int dout_WIDTH  = 31,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0
) (
    input logic          ap_clk,
    input logic          ap_rst,
    mlp_mul_pipe_if.slave bus
);
    localparam int PW         = din0_WIDTH + din1_WIDTH + 1;
    localparam int AW         = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 1;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    typedef struct packed {
        logic          vld;
        logic          acc_en;
        logic          acc_clr;
        logic [PW-1:0] p;
    } beat_t;

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
            $error("mlp_mul_pipe: NUM_STAGE must be in 1..4");
        end
    endgenerate

    logic signed [din0_WIDTH:0] a_ext;
    logic signed [din1_WIDTH:0] b_ext;
    logic signed [PW-1:0]       prod;
    beat_t                      stg_in;
    beat_t                      tap;

    always_comb begin
        a_ext          = {(DIN0_SIGNED != 0) && bus.din0[din0_WIDTH-1], bus.din0};
        b_ext          = {(DIN1_SIGNED != 0) && bus.din1[din1_WIDTH-1], bus.din1};
        prod           = PW'(a_ext) * PW'(b_ext);
        stg_in.vld     = bus.in_valid;
        stg_in.acc_en  = bus.acc_en;
        stg_in.acc_clr = bus.acc_clr;
        stg_in.p       = prod;
    end

    // NUM_STAGE-1 delay registers; the last stage is the result/accumulator register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE - 1; gi++) begin : g_stg
            beat_t src;
            beat_t stage_d;
            beat_t stage_q;
            if (gi == 0) begin : g_first
                assign src = stg_in;
            end else begin : g_next
                assign src = g_stg[gi-1].stage_q;
            end
            always_comb begin
                stage_d = bus.ce ? src : stage_q;
            end
            always_ff @(posedge ap_clk) begin
                if (ap_rst) stage_q <= '0;
                else        stage_q <= stage_d;
            end
        end
        if (NUM_STAGE == 1) begin : g_tap_in
            assign tap = stg_in;
        end else begin : g_tap_pipe
            assign tap = g_stg[NUM_STAGE-2].stage_q;
        end
    endgenerate

    logic [dout_WIDTH-1:0] acc_q, acc_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;
    logic [AW-1:0]         p_ext, acc_ext, sum, v;
    logic [dout_WIDTH-1:0] res;
    logic                  sat;

    // Exact value in AW bits so both wrap and saturation derive from the same sum.
    always_comb begin
        p_ext   = {{(AW-PW){tap.p[PW-1]}}, tap.p};
        acc_ext = {{(AW-dout_WIDTH){RES_SIGNED && acc_q[dout_WIDTH-1]}}, acc_q};
        sum     = acc_ext + p_ext;
        v       = (tap.acc_en && !tap.acc_clr) ? sum : p_ext;
    end

`ifdef MLP_MUL_PIPE_SAT_EN
    logic                  fits;
    logic [dout_WIDTH-1:0] sat_val;
    always_comb begin
        if (RES_SIGNED) begin
            fits    = (v[AW-1:dout_WIDTH-1] == '0) || (v[AW-1:dout_WIDTH-1] == '1);
            sat_val = v[AW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end else begin
            fits    = (v[AW-1:dout_WIDTH] == '0);
            sat_val = v[AW-1] ? '0 : '1;
        end
        res = fits ? v[dout_WIDTH-1:0] : sat_val;
        sat = !fits;
    end
`else
    logic unused_v_hi;
    assign unused_v_hi = ^v[AW-1:dout_WIDTH];
    assign res         = v[dout_WIDTH-1:0];
    assign sat         = 1'b0;
`endif

    always_comb begin
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (bus.ce) begin
            out_valid_d = tap.vld;
            ovf_d       = 1'b0;
            if (tap.vld) begin
                dout_d = res;
                ovf_d  = sat;
                if (tap.acc_en) acc_d = res;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mlp_mul_pipe.sv
// Directed bench for mlp_mul_pipe: default signed/unsigned instance plus an 8x8 unsigned instance.
// Expected values are hand-computed; saturation expectations follow MLP_MUL_PIPE_SAT_EN.
module tb_mlp_mul_pipe;
    logic clk;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    mlp_mul_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(15), .dout_WIDTH(31)) bus ();
    mlp_mul_pipe_if #(.din0_WIDTH(8),  .din1_WIDTH(8),  .dout_WIDTH(16)) bus_u ();

    mlp_mul_pipe #(
        .ID(1), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(15), .dout_WIDTH(31),
        .DIN0_SIGNED(1), .DIN1_SIGNED(0)
    ) u_dut (
        .ap_clk(clk), .ap_rst(rst), .bus(bus)
    );

    mlp_mul_pipe #(
        .ID(2), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
        .DIN0_SIGNED(0), .DIN1_SIGNED(0)
    ) u_dut_u (
        .ap_clk(clk), .ap_rst(rst), .bus(bus_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ua   [8] = '{8'd0, 8'd1, 8'd16, 8'd200, 8'd128, 8'd17, 8'd100, 8'd250};
    logic [7:0]  ub   [8] = '{8'd0, 8'd255, 8'd16, 8'd3, 8'd2, 8'd15, 8'd100, 8'd200};
    logic [15:0] uexp [8] = '{16'd0, 16'd255, 16'd256, 16'd600, 16'd256, 16'd255, 16'd10000, 16'd50000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [14:0] b,
                         input logic en, input logic clr);
        bus.in_valid = v;
        bus.din0     = a;
        bus.din1     = b;
        bus.acc_en   = en;
        bus.acc_clr  = clr;
    endtask

    task automatic drive_u(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus_u.in_valid = v;
        bus_u.din0     = a;
        bus_u.din1     = b;
    endtask

    initial begin
        rst           = 1'b1;
        bus.ce        = 1'b1;
        bus_u.ce      = 1'b1;
        bus_u.acc_en  = 1'b0;
        bus_u.acc_clr = 1'b0;
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        drive_u(1'b0, 8'd0, 8'd0);
        tick(); tick(); tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;

        // Single signed*unsigned beat, 3-cycle latency
        drive(1'b1, 16'hFFFD, 15'd1000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        chk("lat_c1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_c2_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_c3_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_c3_dout", 32'(bus.dout), 32'h7FFFF448);
        chk("lat_c3_ovf", 32'(bus.ovf), 32'd0);
        tick();
        chk("lat_c4_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_c4_dout_hold", 32'(bus.dout), 32'h7FFFF448);

        // Clock-enable stall of two cycles mid-flight
        drive(1'b1, 16'd5, 15'd6, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        tick();
        chk("ce_c2_valid", 32'(bus.out_valid), 32'd0);
        bus.ce = 1'b0;
        tick();
        chk("ce_c3_valid", 32'(bus.out_valid), 32'd0);
        chk("ce_c3_dout", 32'(bus.dout), 32'h7FFFF448);
        tick();
        chk("ce_c4_valid", 32'(bus.out_valid), 32'd0);
        chk("ce_c4_dout", 32'(bus.dout), 32'h7FFFF448);
        bus.ce = 1'b1;
        tick();
        chk("ce_c5_valid", 32'(bus.out_valid), 32'd1);
        chk("ce_c5_dout", 32'(bus.dout), 32'd30);
        bus.ce = 1'b0;
        tick();
        chk("ce_frozen_valid", 32'(bus.out_valid), 32'd1);
        chk("ce_frozen_dout", 32'(bus.dout), 32'd30);
        bus.ce = 1'b1;
        tick();
        chk("ce_after_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back accumulate: 10, 31, 27
        drive(1'b1, 16'd2, 15'd5, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'd3, 15'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hFFFF, 15'd4, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        chk("acc1_valid", 32'(bus.out_valid), 32'd1);
        chk("acc1_dout", 32'(bus.dout), 32'd10);
        tick();
        chk("acc2_valid", 32'(bus.out_valid), 32'd1);
        chk("acc2_dout", 32'(bus.dout), 32'd31);
        tick();
        chk("acc3_valid", 32'(bus.out_valid), 32'd1);
        chk("acc3_dout", 32'(bus.dout), 32'd27);
        tick();
        chk("acc_end_valid", 32'(bus.out_valid), 32'd0);

        // Accumulator overflow
        drive(1'b1, 16'h7FFF, 15'h7FFF, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'h7FFF, 15'h7FFF, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        tick();
        chk("ovf1_dout", 32'(bus.dout), 32'h3FFF0001);
        chk("ovf1_ovf", 32'(bus.ovf), 32'd0);
        tick();
`ifdef MLP_MUL_PIPE_SAT_EN
        chk("ovf2_dout", 32'(bus.dout), 32'h3FFFFFFF);
        chk("ovf2_ovf", 32'(bus.ovf), 32'd1);
`else
        chk("ovf2_dout", 32'(bus.dout), 32'h7FFE0002);
        chk("ovf2_ovf", 32'(bus.ovf), 32'd0);
`endif
        tick();
        chk("ovf_end_valid", 32'(bus.out_valid), 32'd0);

        // Reset while three beats are in flight
        drive(1'b1, 16'd1, 15'd1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'd2, 15'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'd3, 15'd3, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        chk("mrst_dout", 32'(bus.dout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mrst_valid_%0d", i), 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("mrst_dout_after", 32'(bus.dout), 32'd0);
        drive(1'b1, 16'd4, 15'd6, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'd0, 15'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("mrst_acc_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst_acc_dout", 32'(bus.dout), 32'd24);

        // Unsigned 8x8 instance: full-scale product
        drive_u(1'b1, 8'd255, 8'd255);
        tick();
        drive_u(1'b0, 8'd0, 8'd0);
        tick();
        tick();
        chk("u_max_valid", 32'(bus_u.out_valid), 32'd1);
        chk("u_max_dout", 32'(bus_u.dout), 32'd65025);
        tick();

        // Unsigned stream of 8 back-to-back beats
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive_u(1'b1, ua[i], ub[i]);
            else       drive_u(1'b0, 8'd0, 8'd0);
            tick();
            if (i >= 2 && i < 10) begin
                chk($sformatf("u_stream_valid_%0d", i - 2), 32'(bus_u.out_valid), 32'd1);
                chk($sformatf("u_stream_dout_%0d", i - 2), 32'(bus_u.dout), 32'(uexp[i-2]));
            end else if (i == 10) begin
                chk("u_stream_end_valid", 32'(bus_u.out_valid), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
